// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, controller state encoding and the AES-128 inverse-cipher function
package aes_pkg;
  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 128;
  typedef enum logic [1:0] {IDLE, ACCEPT, WAIT, OUT} state_e;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // Field inverse as a^254, so zero maps to zero as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction
  function automatic logic [AES_BLK_W-1:0] aes_dec(input logic [AES_BLK_W-1:0] ct, input logic [AES_KEY_W-1:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [7:0] s [16];
    logic [7:0] u [16];
    logic [AES_BLK_W-1:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 16; j++) s[j] = ct[127-8*j -: 8] ^ w[40 + j/4][31-8*(j%4) -: 8];
    // Byte j sits at row j%4, column j/4; inverse shift rotates each row right by its index.
    for (int r = 9; r >= 0; r--) begin
      for (int j = 0; j < 16; j++)
        u[j] = inv_sbox(s[(j%4) + 4*(((j/4) - (j%4)) & 3)]) ^ w[4*r + j/4][31-8*(j%4) -: 8];
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++)
          s[4*c+k] = (r == 0) ? u[4*c+k] :
                     gmul(u[4*c+k], 8'h0e) ^ gmul(u[4*c+(k+1)%4], 8'h0b) ^
                     gmul(u[4*c+(k+2)%4], 8'h0d) ^ gmul(u[4*c+(k+3)%4], 8'h09);
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction
endpackage

// File: rtl/aes_decr.sv
// aes_decr: combinational AES-128 decrypt core, meant to be timed as a multicycle path
module aes_decr
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] in,
  input  logic [AES_KEY_W-1:0] key,
  output logic [AES_BLK_W-1:0] out
);
  assign out = aes_dec(in, key);
endmodule

// File: rtl/aes_cbc_dec_ctrl.sv
// aes_cbc_dec_ctrl: CBC decrypt sequencer driving an external aes_decr core over a registered multicycle path
module aes_cbc_dec_ctrl
  import aes_pkg::*;
#(
  parameter int CORE_LAT = 4,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic [AES_BLK_W-1:0] iv_in,
  output logic                 busy,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [AES_BLK_W-1:0] s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [AES_BLK_W-1:0] m_data,
  output logic                 m_last,
  output logic [AES_BLK_W-1:0] core_in,
  output logic [AES_KEY_W-1:0] core_key,
  input  logic [AES_BLK_W-1:0] core_out
);
  state_e               state_q, state_d;
  logic [AES_KEY_W-1:0] key_q, key_d;
  logic [AES_BLK_W-1:0] chain_q, chain_d, ct_q, ct_d, core_in_q, core_in_d, m_data_q, m_data_d;
  logic                 last_q, last_d, m_last_q, m_last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    chain_d   = chain_q;
    ct_d      = ct_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    core_in_d = core_in_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    case (state_q)
      IDLE: if (start) begin
        key_d   = key_in;
        chain_d = iv_in;
        state_d = ACCEPT;
      end
      ACCEPT: if (s_valid) begin
        core_in_d = s_data;
        ct_d      = s_data;
        last_d    = s_last;
        cnt_d     = CNT_W'(CORE_LAT - 1);
        state_d   = WAIT;
      end
      WAIT: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      else begin
        m_data_d = core_out ^ chain_q;
        m_last_d = last_q;
        chain_d  = ct_q;
        state_d  = OUT;
      end
      OUT: if (m_ready) begin
        m_last_d = 1'b0;
        state_d  = m_last_q ? IDLE : ACCEPT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      key_q     <= '0;
      chain_q   <= '0;
      ct_q      <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      core_in_q <= '0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      chain_q   <= chain_d;
      ct_q      <= ct_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      core_in_q <= core_in_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end
  assign busy     = state_q != IDLE;
  assign s_ready  = state_q == ACCEPT;
  assign m_valid  = state_q == OUT;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;
  assign core_in  = core_in_q;
  assign core_key = key_q;
endmodule
